// File: rtl/pe_weight_pkg.sv
// pe_weight_pkg: shared state type, address map and sizing helper for the
// PE weight path. The loader and the PE-side decoder both import this package.
package pe_weight_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KERNEL,
    ST_BIAS,
    ST_CHECK,
    ST_DONE
  } loader_state_t;

  localparam logic REGION_KERNEL = 1'b0;
  localparam logic REGION_BIAS   = 1'b1;

  localparam int PE_ID_LSB  = 24;
  localparam int PE_ID_W    = 8;
  localparam int REGION_BIT = 23;
  localparam int INDEX_LSB  = 0;
  localparam int INDEX_W    = 16;

  // Two int8 taps share one 16-bit word; an odd tap count leaves a half word.
  function automatic int words_per_oc(input int taps);
    return (taps + 1) / 2;
  endfunction

endpackage

// File: rtl/pe_weight_loader_if.sv
// Bundles for the weight loader: the inbound host/DMA stream and the
// outbound PE weight-write port.
interface pe_weight_stream_if;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

interface pe_weight_wr_if;
  logic [15:0] weight_wr_data;
  logic [31:0] weight_wr_addr;
  logic        weight_wr_en;

  modport master (output weight_wr_data, output weight_wr_addr, output weight_wr_en);
  modport slave  (input weight_wr_data, input weight_wr_addr, input weight_wr_en);
endinterface

// File: rtl/pe_weight_addr_gen.sv
// pe_weight_addr_gen: word / output-channel counters for the weight loader
// and assembly of the PE write address (PE id, region, index).
module pe_weight_addr_gen
  import pe_weight_pkg::*;
#(
  parameter int                 OUT_CHANNEL  = 4,
  parameter int                 WORDS_PER_OC = 9,
  parameter logic [PE_ID_W-1:0] PE_ID        = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        step,
  input  logic        bias_sel,
  output logic [31:0] addr,
  output logic        word_last,
  output logic        oc_last
);

  localparam logic [INDEX_W-1:0] WORD_MAX = INDEX_W'(WORDS_PER_OC - 1);
  localparam logic [INDEX_W-1:0] OC_MAX   = INDEX_W'(OUT_CHANNEL - 1);
  localparam logic [INDEX_W-1:0] WPO      = INDEX_W'(WORDS_PER_OC);
  localparam logic [INDEX_W-1:0] ONE      = INDEX_W'(1);

  logic [INDEX_W-1:0] w;
  logic [INDEX_W-1:0] oc;
  logic [INDEX_W-1:0] index;

  assign word_last = (w == WORD_MAX);
  assign oc_last   = (oc == OC_MAX);

  // Advance w per kernel beat (oc on wrap) or oc per bias beat; both wrap to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w  <= '0;
      oc <= '0;
    end else if (clear) begin
      w  <= '0;
      oc <= '0;
    end else if (step) begin
      if (bias_sel || word_last) begin
        w  <= '0;
        oc <= oc_last ? '0 : oc + ONE;
      end else begin
        w <= w + ONE;
      end
    end
  end

  // Kernel words are laid out channel-major; bias words are indexed by channel.
  always_comb begin
    index = bias_sel ? oc : (oc * WPO + w);
    addr  = '0;
    addr[PE_ID_LSB +: PE_ID_W] = PE_ID;
    addr[REGION_BIT]           = bias_sel ? REGION_BIAS : REGION_KERNEL;
    addr[INDEX_LSB +: INDEX_W] = index;
  end

endmodule

// File: rtl/pe_weight_loader.sv
// pe_weight_loader: streams kernel words then per-channel biases into one
// PE's weight RAMs. Optional trailing checksum: PE_WEIGHT_LOADER_CHECKSUM_EN.
module pe_weight_loader
  import pe_weight_pkg::*;
#(
  parameter int         IN_CHANNEL  = 2,
  parameter int         OUT_CHANNEL = 4,
  parameter int         KERNEL_0    = 3,
  parameter int         KERNEL_1    = 3,
  parameter logic [7:0] PE_ID       = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  pe_weight_stream_if.slave s,
  pe_weight_wr_if.master    wr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int TAPS         = KERNEL_0 * KERNEL_1 * IN_CHANNEL;
  localparam int WORDS_PER_OC = words_per_oc(TAPS);

  loader_state_t state;
  loader_state_t state_nxt;

  logic        accept;
  logic        word_last;
  logic        oc_last;
  logic [31:0] beat_addr;

  logic        clear_d;
  logic        write_d;
  logic        ready_d;
  logic        busy_d;
  logic        done_d;

  logic        ready_q;
  logic        busy_q;
  logic        done_q;
  logic        wr_en_q;
  logic [15:0] wr_data_q;
  logic [31:0] wr_addr_q;

  assign accept = s.s_valid & ready_q;

  pe_weight_addr_gen #(
    .OUT_CHANNEL  (OUT_CHANNEL),
    .WORDS_PER_OC (WORDS_PER_OC),
    .PE_ID        (PE_ID)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear_d),
    .step      (write_d),
    .bias_sel  (state == ST_BIAS),
    .addr      (beat_addr),
    .word_last (word_last),
    .oc_last   (oc_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state: move on only when the final beat of a phase is accepted.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_KERNEL;
      ST_KERNEL: if (accept && word_last && oc_last) state_nxt = ST_BIAS;
      ST_BIAS: begin
        if (accept && oc_last) begin
`ifdef PE_WEIGHT_LOADER_CHECKSUM_EN
          state_nxt = ST_CHECK;
`else
          state_nxt = ST_DONE;
`endif
        end
      end
`ifdef PE_WEIGHT_LOADER_CHECKSUM_EN
      ST_CHECK:  if (accept) state_nxt = ST_DONE;
`endif
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Output decode; ready/busy look at the next state so their registers line up with it.
  always_comb begin
    clear_d = (state == ST_IDLE) && start;
    write_d = accept && ((state == ST_KERNEL) || (state == ST_BIAS));
    ready_d = (state_nxt == ST_KERNEL) || (state_nxt == ST_BIAS) || (state_nxt == ST_CHECK);
    busy_d  = (state_nxt != ST_IDLE);
    done_d  = (state == ST_DONE);
  end

  // Output registers; write data/address hold between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      wr_addr_q <= '0;
    end else begin
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wr_en_q <= write_d;
      if (write_d) begin
        wr_data_q <= s.s_data;
        wr_addr_q <= beat_addr;
      end
    end
  end

  assign s.s_ready         = ready_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign wr.weight_wr_en   = wr_en_q;
  assign wr.weight_wr_data = wr_data_q;
  assign wr.weight_wr_addr = wr_addr_q;

`ifdef PE_WEIGHT_LOADER_CHECKSUM_EN
  logic [15:0] sum_q;
  logic        err_q;

  // Wrap-around sum of every written word, compared against the trailing beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else if (clear_d) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else if (write_d) begin
      sum_q <= sum_q + s.s_data;
    end else if (accept && (state == ST_CHECK) && (s.s_data != sum_q)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/pe_weight_loader.md
# pe_weight_loader

Host-side initiator for the PE weight-write port. Accepts a 16-bit weight stream over a valid/ready handshake and drives `weight_wr_data` / `weight_wr_addr` / `weight_wr_en` of one `pe_incha_single` instance. Sequences all kernel words (two int8 taps per write) for every output channel, then one int16 bias per output channel, then reports completion. Sits between the DMA/host stream and each PE's kernel and bias RAMs.

## Interface
- `IN_CHANNEL`, default 2, input channels of the target PE
- `OUT_CHANNEL`, default 4, output channels of the target PE
- `KERNEL_0`, default 3, kernel height
- `KERNEL_1`, default 3, kernel width
- `PE_ID`, default 0, 8-bit PE select placed in `addr[31:24]`
- Derived: `TAPS = KERNEL_0*KERNEL_1*IN_CHANNEL`; `WORDS_PER_OC = ceil(TAPS/2)`

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low; clock `clk`
- `start`  in  1  begin load; sampled only in IDLE
- `s_data`  in  16  stream word
- `s_valid`  in  1  stream word valid
- `s_ready`  out  1  loader accepts `s_data` this cycle
- `weight_wr_data`  out  16  write data
- `weight_wr_addr`  out  32  write address
- `weight_wr_en`  out  1  write strobe, one word per cycle
- `busy`  out  1  load in progress
- `done`  out  1  one-cycle pulse after the final write
- `err`  out  1  checksum mismatch, sticky until next `start` (only with the checksum macro)

## Operation
- FSM: IDLE -> KERNEL -> BIAS -> (CHECK) -> DONE -> IDLE.
- IDLE: `s_ready=0`, `busy=0`. `start=1` -> KERNEL; counters cleared.
- KERNEL: `s_ready=1`. Each accepted beat (`s_valid & s_ready`) is one write. `w` counts 0..WORDS_PER_OC-1; on wrap, `oc` increments. After beat (`oc=OUT_CHANNEL-1`, `w=WORDS_PER_OC-1`) -> BIAS with `oc=0`.
- Byte packing: `s_data[7:0]` is tap 2k, `s_data[15:8]` is tap 2k+1. If TAPS is odd, the last word of each channel carries the final tap in `[7:0]`. The host sends `[15:8]=0` in that case and the loader forwards it unchanged.
- BIAS: `s_ready=1`. One beat per output channel. The signed int16 is written as-is. After `oc=OUT_CHANNEL-1` -> CHECK if the macro is defined, else DONE.
- Address: `addr[31:24]=PE_ID`; `addr[23]` is the region (0 = kernel, 1 = bias); `addr[22:16]=0`.
  - Kernel: `addr[15:0] = oc*WORDS_PER_OC + w`.
  - Bias: `addr[15:0] = oc`.
- DONE: `done=1` for one cycle, then -> IDLE.
- `start` outside IDLE is ignored. `s_valid` while `s_ready=0` is ignored and the data is not consumed.

## Timing
- All outputs are registered. Reset values: `weight_wr_en=0`, `weight_wr_data=0`, `weight_wr_addr=0`, `s_ready=0`, `busy=0`, `done=0`, `err=0`; FSM in IDLE.
- `start` at cycle N -> `busy=1` and `s_ready=1` from N+1.
- Beat accepted at cycle N -> `weight_wr_en=1` with its data and address at N+1. Without a beat, `weight_wr_en=0`; data and address hold their last values.
- Full-rate throughput: one write per cycle. Stalls (`s_valid=0`) simply insert idle cycles.
- `s_ready` deasserts in the cycle after the last bias beat, so that beat is never over-accepted.
- The last write's `weight_wr_en` is at N+1. `done` pulses at N+2, and `busy` falls together with `done`.
- Reset mid-load: immediate return to IDLE, all outputs to reset values, and partial RAM contents are left as-is. A full reload is required.
- Minimum load length: `OUT_CHANNEL*(WORDS_PER_OC+1)` beats (+1 with checksum). For the defaults this is 4*(9+1)=40 beats.

## Configuration
- Macro `PE_WEIGHT_LOADER_CHECKSUM_EN`.
- Defined:
  - A 16-bit wrap-around sum is kept over all kernel and bias words, cleared on `start`.
  - CHECK accepts one extra beat. That beat is not written to the PE.
  - If the beat differs from the sum, `err=1` (sticky until the next `start`); `done` still pulses.
- Undefined: no CHECK state, no accumulator, and `err` is tied to 0.

## Structure
- Shared package `pe_weight_pkg`:
  - FSM state enum.
  - Region constants `REGION_KERNEL=0`, `REGION_BIAS=1`.
  - Field positions for PE_ID, region and index.
  - Function `words_per_oc(taps)`. The PE-side decoder uses the same package.
- One sub-module `pe_weight_addr_gen`: the `w`/`oc` counters with wrap and limit flags, plus address assembly. The top level holds the FSM, handshake and output registers.

## Test plan
- Defaults, continuous `s_valid`, data = beat index:
  - 36 kernel writes at `addr` 0x0000_0000..0x0000_0023, then 4 bias writes at 0x0080_0000..0x0080_0003.
  - Writes are back-to-back; `done` pulses 1 cycle after the last write.
- Random `s_valid` gaps:
  - Write sequence identical to the continuous case.
  - `weight_wr_en` appears only at accepted beat + 1.
  - No beat is lost or duplicated.
- TAPS odd (`KERNEL_0=KERNEL_1=3`, `IN_CHANNEL=1`, `OUT_CHANNEL=2`): `WORDS_PER_OC=5`; kernel addresses 0..9, bias addresses 0x0080_0000..0x0080_0001.
- `rst_n` low after 10 kernel beats:
  - All outputs are 0 and the FSM is in IDLE.
  - A new `start` restarts at `addr` 0.
  - `start` pulses during a load are ignored.
- With `PE_WEIGHT_LOADER_CHECKSUM_EN`:
  - Correct trailing sum -> `err=0` and `done` pulses.
  - Trailing sum off by one -> `err=1` and `done` pulses.
  - The checksum word produces no `weight_wr_en`.
- `PE_ID=0x5A`: every write has `addr[31:24]=0x5A`.
